mips_mem_responder: RTL and testbench



---
 rtl/mips_mem_responder_if.sv | 40 ++++
 rtl/mips_mem_responder.sv | 65 ++++++
 tb/tb_mips_mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: fetch and data valid/ready request/response channels between core and memory
interface mips_mem_responder_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic        dm_req_we;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
`ifdef MIPS_MEM_BYTE_EN
  logic [3:0]  dm_req_be;
`endif
  logic        dm_rsp_valid;
  logic        dm_rsp_ready;
  logic [31:0] dm_rsp_data;
  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
`ifdef MIPS_MEM_BYTE_EN
    output dm_req_be,
`endif
    output dm_rsp_ready,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data
  );
  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
`ifdef MIPS_MEM_BYTE_EN
    input  dm_req_be,
`endif
    input  dm_rsp_ready,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data
  );
endinterface

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: shared single-port word memory for fetch and data with starvation-bounded arbitration; MIPS_MEM_BYTE_EN adds store byte enables
module mips_mem_responder #(
  parameter int DEPTH      = 1024,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk1,
  input  logic                  rst,
  mips_mem_responder_if.slave   bus,
  output logic                  err_addr
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] starve_cnt;
  logic          if_slot, dm_slot, if_elig, dm_elig, force_if, if_fire, dm_fire, in_range;
  logic [31:0]   addr, rdata;
  logic [AW-1:0] idx;
  always_comb begin
    if_slot          = !bus.if_rsp_valid || bus.if_rsp_ready;
    dm_slot          = !bus.dm_rsp_valid || bus.dm_rsp_ready;
    force_if         = starve_cnt == CW'(STARVE_MAX);
    dm_elig          = bus.dm_req_valid && (bus.dm_req_we || dm_slot);
    if_elig          = bus.if_req_valid && if_slot;
    bus.if_req_ready = !rst && if_slot && (!dm_elig || force_if);
    bus.dm_req_ready = !rst && (bus.dm_req_we || dm_slot) && !(if_elig && force_if);
    if_fire          = bus.if_req_valid && bus.if_req_ready;
    dm_fire          = bus.dm_req_valid && bus.dm_req_ready;
    addr             = if_fire ? bus.if_req_addr : bus.dm_req_addr;
    idx              = addr[AW-1:0];
    in_range         = addr < 32'(DEPTH);
    rdata            = in_range ? mem[idx] : '0;
  end
  always_ff @(posedge clk1) begin
    if (dm_fire && bus.dm_req_we && in_range) begin
`ifdef MIPS_MEM_BYTE_EN
      for (int b = 0; b < 4; b++)
        if (bus.dm_req_be[b]) mem[idx][8*b +: 8] <= bus.dm_req_wdata[8*b +: 8];
`else
      mem[idx] <= bus.dm_req_wdata;
`endif
    end
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= '0;
      bus.dm_rsp_valid <= 1'b0;
      bus.dm_rsp_data  <= '0;
      err_addr         <= 1'b0;
      starve_cnt       <= '0;
    end else begin
      if (if_fire) begin
        bus.if_rsp_valid <= 1'b1;
        bus.if_rsp_data  <= rdata;
      end else if (bus.if_rsp_ready) bus.if_rsp_valid <= 1'b0;
      if (dm_fire && !bus.dm_req_we) begin
        bus.dm_rsp_valid <= 1'b1;
        bus.dm_rsp_data  <= rdata;
      end else if (bus.dm_rsp_ready) bus.dm_rsp_valid <= 1'b0;
      if ((if_fire || dm_fire) && !in_range) err_addr <= 1'b1;
      if (if_fire || !bus.if_req_valid) starve_cnt <= '0;
      else if (dm_fire && !force_if) starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed self-checking bench for mips_mem_responder
module tb_mips_mem_responder;
  logic clk1 = 1'b0;
  logic rst;
  logic err_addr;
  int   errs = 0;
  int   checks = 0;
  mips_mem_responder_if bus();
  mips_mem_responder #(.DEPTH(1024), .AW(10), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .bus(bus.slave), .err_addr(err_addr)
  );
  always #5 clk1 = ~clk1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask
  task automatic dm_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.dm_req_valid = 1'b1;
    bus.dm_req_we    = we;
    bus.dm_req_addr  = a;
    bus.dm_req_wdata = d;
`ifdef MIPS_MEM_BYTE_EN
    bus.dm_req_be    = be;
`endif
    #1;
    chk("dm_req_ready", 32'(bus.dm_req_ready), 32'd1);
    tick();
    bus.dm_req_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_rsp_ready = 1'b1;
    bus.dm_req_valid = 1'b0; bus.dm_req_we = 1'b0; bus.dm_req_addr = '0;
    bus.dm_req_wdata = '0;   bus.dm_rsp_ready = 1'b1;
`ifdef MIPS_MEM_BYTE_EN
    bus.dm_req_be = 4'hF;
`endif
    tick(); tick();
    chk("init_if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
    chk("init_dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
    chk("init_err", 32'(err_addr), 32'd0);
    rst = 1'b0;
    dm_op(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF);
    dm_op(1'b1, 32'd0, 32'h2801_000A, 4'hF);
    dm_op(1'b1, 32'd3, 32'h0000_3333, 4'hF);
    dm_op(1'b1, 32'd4, 32'h4444_4444, 4'hF);
    chk("store_no_rsp", 32'(bus.dm_rsp_valid), 32'd0);
    bus.dm_rsp_ready = 1'b0;
    dm_op(1'b0, 32'd5, 32'h0, 4'hF);
    chk("pend_valid", 32'(bus.dm_rsp_valid), 32'd1);
    chk("pend_data", bus.dm_rsp_data, 32'hDEAD_BEEF);
    rst = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd0;
    bus.dm_req_valid = 1'b1; bus.dm_req_we = 1'b1; bus.dm_req_addr = 32'd5; bus.dm_req_wdata = 32'h0000_0BAD;
    #1;
    chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    chk("rst_dm_ready", 32'(bus.dm_req_ready), 32'd0);
    tick();
    chk("rst_if_ready2", 32'(bus.if_req_ready), 32'd0);
    chk("rst_dm_ready2", 32'(bus.dm_req_ready), 32'd0);
    tick();
    chk("rst_dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
    chk("rst_dm_rsp_data", bus.dm_rsp_data, 32'h0);
    chk("rst_if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
    chk("rst_err", 32'(err_addr), 32'd0);
    rst = 1'b0;
    bus.if_req_valid = 1'b0; bus.dm_req_valid = 1'b0; bus.dm_rsp_ready = 1'b1;
    dm_op(1'b0, 32'd5, 32'h0, 4'hF);
    chk("no_spurious_write", bus.dm_rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("rsp_drained", 32'(bus.dm_rsp_valid), 32'd0);
    dm_op(1'b1, 32'd7, 32'h1234_5678, 4'hF);
    dm_op(1'b0, 32'd7, 32'h0, 4'hF);
    chk("ld7_valid", 32'(bus.dm_rsp_valid), 32'd1);
    chk("ld7_data", bus.dm_rsp_data, 32'h1234_5678);
    chk("ld7_no_if", 32'(bus.if_rsp_valid), 32'd0);
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd0;
    bus.dm_req_valid = 1'b1; bus.dm_req_we = 1'b0; bus.dm_req_addr = 32'd5;
    for (int i = 0; i < 10; i++) begin
      logic g;
      g = (i == 4) || (i == 9);
      #1;
      chk($sformatf("arb_if_ready_%0d", i), 32'(bus.if_req_ready), 32'(g));
      chk($sformatf("arb_dm_ready_%0d", i), 32'(bus.dm_req_ready), 32'(!g));
      tick();
      chk($sformatf("arb_if_rsp_%0d", i), 32'(bus.if_rsp_valid), 32'(g));
      if (g) chk($sformatf("arb_if_data_%0d", i), bus.if_rsp_data, 32'h2801_000A);
      else chk($sformatf("arb_dm_data_%0d", i), bus.dm_rsp_data, 32'hDEAD_BEEF);
    end
    bus.if_req_valid = 1'b0; bus.dm_req_valid = 1'b0;
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'd3;
    #1;
    chk("bp_first_ready", 32'(bus.if_req_ready), 32'd1);
    tick();
    chk("bp_first_data", bus.if_rsp_data, 32'h0000_3333);
    bus.if_rsp_ready = 1'b0; bus.if_req_addr = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), 32'(bus.if_req_ready), 32'd0);
      chk($sformatf("bp_valid_%0d", i), 32'(bus.if_rsp_valid), 32'd1);
      chk($sformatf("bp_data_%0d", i), bus.if_rsp_data, 32'h0000_3333);
      tick();
    end
    bus.if_rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.if_req_ready), 32'd1);
    tick();
    bus.if_req_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.if_rsp_valid), 32'd1);
    chk("bp_next_data", bus.if_rsp_data, 32'h4444_4444);
    tick();
    chk("bp_drained", 32'(bus.if_rsp_valid), 32'd0);
    chk("oor_err_before", 32'(err_addr), 32'd0);
    dm_op(1'b1, 32'd1024, 32'h1, 4'hF);
    chk("oor_err_set", 32'(err_addr), 32'd1);
    dm_op(1'b0, 32'd1024, 32'h0, 4'hF);
    chk("oor_ld_valid", 32'(bus.dm_rsp_valid), 32'd1);
    chk("oor_ld_data", bus.dm_rsp_data, 32'h0);
    dm_op(1'b0, 32'd0, 32'h0, 4'hF);
    chk("oor_loc0", bus.dm_rsp_data, 32'h2801_000A);
    tick(); tick();
    chk("oor_err_sticky", 32'(err_addr), 32'd1);
`ifdef MIPS_MEM_BYTE_EN
    dm_op(1'b1, 32'd9, 32'hAABB_CCDD, 4'hF);
    dm_op(1'b1, 32'd9, 32'h1122_3344, 4'b0101);
    dm_op(1'b0, 32'd9, 32'h0, 4'b0000);
    chk("be_merge", bus.dm_rsp_data, 32'hAA22_CC44);
    dm_op(1'b1, 32'd9, 32'hFFFF_FFFF, 4'b0000);
    dm_op(1'b0, 32'd9, 32'h0, 4'hF);
    chk("be_none", bus.dm_rsp_data, 32'hAA22_CC44);
`else
    dm_op(1'b1, 32'd9, 32'hAABB_CCDD, 4'hF);
    dm_op(1'b1, 32'd9, 32'h1122_3344, 4'hF);
    dm_op(1'b0, 32'd9, 32'h0, 4'hF);
    chk("full_word_store", bus.dm_rsp_data, 32'h1122_3344);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
